gcd_lcm_mmio_slave: RTL and testbench

Memory-mapped GCD/LCM coprocessor that sits on the RISC-V core's data-memory port, next to data memory, as the responder to the core's store/load traffic. It captures operands and commands from core stores (`MemWrite`, `DataAdr`, `WriteData`), runs an iterative 32-bit GCD (or LCM) computation, and returns status and results on core loads. The core may also launch a computation directly with its `Start` strobe.

---
 rtl/gcd_lcm_mmio_slave_pkg.sv | 34 +++
 rtl/gcd_lcm_mmio_slave_if.sv | 22 ++
 rtl/gcd_lcm_mmio_slave_engine.sv | 124 ++++++++++++
 rtl/gcd_lcm_mmio_slave.sv | 96 +++++++++
 tb/tb_gcd_lcm_mmio_slave.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_lcm_mmio_slave_pkg.sv
// Shared definitions for the GCD/LCM MMIO coprocessor: register offsets, bit
// positions and the engine state type. COPROC_LCM_EN selects the LCM build.
package coproc_pkg;

    localparam logic [4:0]  OFS_A      = 5'd0;
    localparam logic [4:0]  OFS_B      = 5'd4;
    localparam logic [4:0]  OFS_CTRL   = 5'd8;
    localparam logic [4:0]  OFS_STATUS = 5'd12;
    localparam logic [4:0]  OFS_RESULT = 5'd16;
    localparam logic [31:0] WIN_BYTES  = 32'd20;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_OP_BIT    = 1;
    localparam int ST_BUSY_BIT    = 0;
    localparam int ST_DONE_BIT    = 1;
    localparam int ST_OVF_BIT     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } coproc_state_t;

    function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                                input logic ovf);
        logic [31:0] w;
        w = 32'd0;
        w[ST_BUSY_BIT] = busy;
        w[ST_DONE_BIT] = done;
        w[ST_OVF_BIT]  = ovf;
        return w;
    endfunction

endpackage

// File: rtl/gcd_lcm_mmio_slave_if.sv
// Core data-memory port as seen by the coprocessor (store/load traffic plus
// the direct Start strobe and status lines back to the core).
interface gcd_lcm_mmio_slave_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        Start;
    logic [31:0] ReadData;
    logic        Hit;
    logic        Busy;
    logic        Done;

    modport master (
        output MemWrite, DataAdr, WriteData, Start,
        input  ReadData, Hit, Busy, Done
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, Start,
        output ReadData, Hit, Busy, Done
    );
endinterface

// File: rtl/gcd_lcm_mmio_slave_engine.sv
// Iterative GCD/LCM engine: FSM, private x/y working copies, RESULT and ovf.
// The LCM adders and ovf flag exist only when COPROC_LCM_EN is defined.
module gcd_lcm_engine
    import coproc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf
);

`ifdef COPROC_LCM_EN
    localparam logic LCM_BUILD = 1'b1;
`else
    localparam logic LCM_BUILD = 1'b0;
`endif

    coproc_state_t state_r;
    logic [31:0]   x_r;
    logic [31:0]   y_r;
    logic [31:0]   result_r;
    logic          op_s;

    assign op_s = op & LCM_BUILD;

`ifdef COPROC_LCM_EN
    // LCM walks multiples of the operands captured at launch, not the live registers
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        op_r;
    logic        ovf_r;
    logic [32:0] sum_x_s;
    logic [32:0] sum_y_s;

    assign sum_x_s = {1'b0, x_r} + {1'b0, a_r};
    assign sum_y_s = {1'b0, y_r} + {1'b0, b_r};
    assign ovf     = ovf_r;
`else
    assign ovf     = 1'b0;
`endif

    // Job FSM and datapath; a start while in CALC is dropped, not queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            x_r      <= 32'd0;
            y_r      <= 32'd0;
            result_r <= 32'd0;
`ifdef COPROC_LCM_EN
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            op_r     <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        x_r <= a;
                        y_r <= b;
`ifdef COPROC_LCM_EN
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op_s;
                        ovf_r <= 1'b0;
`endif
                        if ((a == 32'd0) || (b == 32'd0)) begin
                            result_r <= op_s ? 32'd0 : (a | b);
                            state_r  <= DONE;
                        end else begin
                            state_r  <= CALC;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                CALC: begin
                    if (x_r == y_r) begin
                        result_r <= x_r;
                        state_r  <= DONE;
`ifdef COPROC_LCM_EN
                    end else if (op_r) begin
                        if (x_r < y_r) begin
                            if (sum_x_s[32]) begin
                                ovf_r    <= 1'b1;
                                result_r <= 32'd0;
                                state_r  <= DONE;
                            end else begin
                                x_r <= sum_x_s[31:0];
                            end
                        end else begin
                            if (sum_y_s[32]) begin
                                ovf_r    <= 1'b1;
                                result_r <= 32'd0;
                                state_r  <= DONE;
                            end else begin
                                y_r <= sum_y_s[31:0];
                            end
                        end
`endif
                    end else if (x_r > y_r) begin
                        x_r <= x_r - y_r;
                    end else begin
                        y_r <= y_r - x_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_r == CALC);
    assign done   = (state_r == DONE);
    assign result = result_r;

endmodule

// File: rtl/gcd_lcm_mmio_slave.sv
// GCD/LCM coprocessor on the core data-memory port: address decode, A/B/CTRL
// registers and the combinational read mux. COPROC_LCM_EN enables LCM jobs.
module gcd_lcm_mmio_slave
    import coproc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd96
) (
    input  logic                clk,
    input  logic                reset,
    gcd_lcm_mmio_slave_if.slave bus
);

    logic [31:0] offset_s;
    logic [4:0]  word_ofs_s;
    logic        hit_s;
    logic        wr_a_s;
    logic        wr_b_s;
    logic        wr_ctrl_s;
    logic        start_s;
    logic        op_s;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        ctrl_op_r;
    logic [31:0] rdata_s;
    logic        busy_s;
    logic        done_s;
    logic        ovf_s;
    logic [31:0] result_s;

    // Addresses below BASE_ADDR wrap to a huge offset and so never hit
    assign offset_s   = bus.DataAdr - BASE_ADDR;
    assign hit_s      = (offset_s < WIN_BYTES);
    assign word_ofs_s = {offset_s[4:2], 2'b00};

    assign wr_a_s    = bus.MemWrite & hit_s & (word_ofs_s == OFS_A);
    assign wr_b_s    = bus.MemWrite & hit_s & (word_ofs_s == OFS_B);
    assign wr_ctrl_s = bus.MemWrite & hit_s & (word_ofs_s == OFS_CTRL);

    assign start_s = bus.Start | (wr_ctrl_s & bus.WriteData[CTRL_START_BIT]);
    assign op_s    = wr_ctrl_s ? bus.WriteData[CTRL_OP_BIT] : ctrl_op_r;

    // Architectural operand and op registers, writable at any time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            ctrl_op_r <= 1'b0;
        end else begin
            if (wr_a_s) begin
                a_r <= bus.WriteData;
            end
            if (wr_b_s) begin
                b_r <= bus.WriteData;
            end
            if (wr_ctrl_s) begin
                ctrl_op_r <= bus.WriteData[CTRL_OP_BIT];
            end
        end
    end

    gcd_lcm_engine u_engine (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s),
        .op     (op_s),
        .a      (a_r),
        .b      (b_r),
        .busy   (busy_s),
        .done   (done_s),
        .result (result_s),
        .ovf    (ovf_s)
    );

    // Same-cycle read mux so a load sees its data without a wait state
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s) begin
            case (word_ofs_s)
                OFS_A:      rdata_s = a_r;
                OFS_B:      rdata_s = b_r;
                OFS_CTRL:   rdata_s = 32'd0;
                OFS_STATUS: rdata_s = pack_status(busy_s, done_s, ovf_s);
                OFS_RESULT: rdata_s = result_s;
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.ReadData = rdata_s;
    assign bus.Hit      = hit_s;
    assign bus.Busy     = busy_s;
    assign bus.Done     = done_s;

endmodule

// File: tb/tb_gcd_lcm_mmio_slave.sv
// Scoreboard bench for gcd_lcm_mmio_slave: stimulus queues expected values, a
// negedge monitor compares them. LCM vectors run only with COPROC_LCM_EN.
module tb_gcd_lcm_mmio_slave;

    localparam logic [31:0] BASE = 32'd96;
    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;
    localparam int K_HIT  = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [31:0] act;
    chk_t q[$];

    gcd_lcm_mmio_slave_if bus ();

    gcd_lcm_mmio_slave #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drain every expectation queued during this cycle
    always @(negedge clk) begin
        while (q.size() != 0) begin
            chk_t c;
            c = q.pop_front();
            case (c.kind)
                K_RD:    act = bus.ReadData;
                K_BUSY:  act = {31'd0, bus.Busy};
                K_DONE:  act = {31'd0, bus.Done};
                default: act = {31'd0, bus.Hit};
            endcase
            n_vec = n_vec + 1;
            if (act !== c.exp) begin
                n_err = n_err + 1;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] ofs, input logic [31:0] data);
        bus.DataAdr   = BASE + {27'd0, ofs};
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic probe(input logic [31:0] addr, input int kind,
                         input logic [31:0] exp, input string name);
        bus.DataAdr = addr;
        expect_val(kind, exp, name);
        tick();
    endtask

    task automatic rd(input logic [4:0] ofs, input logic [31:0] exp, input string name);
        probe(BASE + {27'd0, ofs}, K_RD, exp, name);
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int i;
        i = 0;
        while ((bus.Done !== 1'b1) && (i < max_cycles)) begin
            tick();
            i = i + 1;
        end
        n_vec = n_vec + 1;
        if (bus.Done !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL %s: Done not seen within %0d cycles", name, max_cycles);
        end
        expect_val(K_DONE, 32'd1, name);
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl,
                           input int max_cycles, input logic [31:0] exp_res,
                           input logic [31:0] exp_st, input string name);
        wr(5'd0, a);
        wr(5'd4, b);
        wr(5'd8, ctrl);
        wait_done(max_cycles, {name, "_done"});
        rd(5'd16, exp_res, {name, "_result"});
        rd(5'd12, exp_st, {name, "_status"});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'd0;
        bus.WriteData = 32'd0;
        bus.Start     = 1'b0;
        tick();
        tick();

        n_vec = n_vec + 1;
        if ((bus.Busy !== 1'b0) || (bus.Done !== 1'b0) || (bus.ReadData !== 32'd0)) begin
            n_err = n_err + 1;
            $display("FAIL rst_direct: Busy=%b Done=%b ReadData=0x%08h",
                     bus.Busy, bus.Done, bus.ReadData);
        end

        // Reset state and window decode
        expect_val(K_BUSY, 32'd0, "rst_busy");
        expect_val(K_DONE, 32'd0, "rst_done");
        rd(5'd16, 32'd0, "rst_result");
        rd(5'd12, 32'd0, "rst_status");
        probe(32'd0, K_HIT, 32'd0, "hit_low");
        probe(32'd0, K_RD, 32'd0, "rdata_nohit");
        probe(BASE + 32'd20, K_HIT, 32'd0, "hit_past_end");
        probe(BASE + 32'd16, K_HIT, 32'd1, "hit_last_word");
        probe(BASE, K_HIT, 32'd1, "hit_first_word");
        reset = 1'b0;
        tick();

        // GCD(75,50): Busy next cycle, 3 CALC cycles, then Done
        wr(5'd0, 32'd75);
        wr(5'd4, 32'd50);
        rd(5'd0, 32'd75, "reg_a_rb");
        rd(5'd8, 32'd0, "ctrl_reads_0");
        wr(5'd8, 32'd1);
        expect_val(K_BUSY, 32'd1, "g75_busy_c1");
        expect_val(K_DONE, 32'd0, "g75_done_c1");
        rd(5'd12, 32'd1, "g75_status_busy");
        tick();
        expect_val(K_BUSY, 32'd1, "g75_busy_c3");
        tick();
        expect_val(K_BUSY, 32'd0, "g75_busy_end");
        expect_val(K_DONE, 32'd1, "g75_done");
        rd(5'd16, 32'd25, "g75_result");
        rd(5'd12, 32'd2, "g75_status");

`ifdef COPROC_LCM_EN
        run_job(32'd5, 32'd25, 32'd3, 40, 32'd25, 32'd2, "lcm5_25");
        run_job(32'd4, 32'd6, 32'd3, 40, 32'd12, 32'd2, "lcm4_6");
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 3, 32'd0, 32'd6, "lcm_ovf");
        run_job(32'd0, 32'd7, 32'd3, 1, 32'd0, 32'd2, "lcm_zero");
`else
        run_job(32'd4, 32'd6, 32'd3, 40, 32'd2, 32'd2, "op_ignored");
`endif

        // CTRL store with start=0 only latches op: nothing launches
        wr(5'd8, 32'd0);
        expect_val(K_BUSY, 32'd0, "ctrl0_no_busy");
        expect_val(K_DONE, 32'd1, "ctrl0_done_kept");
        tick();

        // Zero-operand jobs via the Start strobe finish one cycle later
        wr(5'd0, 32'd0);
        wr(5'd4, 32'd9);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        expect_val(K_DONE, 32'd1, "z09_done");
        expect_val(K_BUSY, 32'd0, "z09_busy");
        rd(5'd16, 32'd9, "z09_result");
        wr(5'd4, 32'd0);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        expect_val(K_DONE, 32'd1, "z00_done");
        rd(5'd16, 32'd0, "z00_result");

        // Restart from DONE; stores and starts during CALC leave the job alone
        wr(5'd0, 32'd1000);
        wr(5'd4, 32'd1);
        wr(5'd8, 32'd1);
        expect_val(K_DONE, 32'd0, "g1000_done_drop");
        expect_val(K_BUSY, 32'd1, "g1000_busy");
        wr(5'd0, 32'd7);
        wr(5'd8, 32'd1);
        wait_done(1100, "g1000_done");
        rd(5'd16, 32'd1, "g1000_result");
        rd(5'd0, 32'd7, "g1000_reg_a");

        // Reset in the middle of CALC clears everything at once
        wr(5'd0, 32'd1000);
        wr(5'd8, 32'd1);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        expect_val(K_BUSY, 32'd0, "rstmid_busy");
        expect_val(K_DONE, 32'd0, "rstmid_done");
        rd(5'd16, 32'd0, "rstmid_result");
        rd(5'd0, 32'd0, "rstmid_reg_a");
        reset = 1'b0;
        tick();
        run_job(32'd12, 32'd18, 32'd1, 20, 32'd6, 32'd2, "g12_18");

        // Store to A on the same edge as Start: the job uses the old A (12)
        bus.DataAdr   = BASE;
        bus.WriteData = 32'd8;
        bus.MemWrite  = 1'b1;
        bus.Start     = 1'b1;
        tick();
        bus.MemWrite  = 1'b0;
        bus.Start     = 1'b0;
        wait_done(20, "same_edge_done");
        rd(5'd16, 32'd6, "same_edge_result");
        rd(5'd0, 32'd8, "same_edge_reg_a");

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
